rhd_cmd_sequencer: RTL and testbench

- Per-frame command scheduler in front of the RHD SPI engine (CS/SCLK/MOSI1/MOSI2).
- Each frame issues 35 16-bit command words: CONVERT for channels 0..31, then 3 auxiliary slots.
- Aux slots drain a small host-written config command FIFO; when it is empty they carry a dummy register read.
- Counts frames into batches of packet_len and flags batch completion for the stream packer.

---
 rtl/rhd_cmd_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_rhd_cmd_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rhd_cmd_sequencer.sv
// Per-frame command scheduler for the RHD SPI engine: CONVERT slots, FIFO-fed aux slots, batch counting.
// Optional macro RHD_SEQ_CAL_EN adds a CALIBRATE preamble on each IDLE->active transition.
module rhd_cmd_sequencer #(
  parameter int          NUM_CH    = 32,
  parameter int          NUM_AUX   = 3,
  parameter int          CFG_DEPTH = 8,
  parameter logic [15:0] DUMMY_CMD = 16'hE800
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic                         enable,
  input  logic [15:0]                  packet_len,
  input  logic                         cfg_wr,
  input  logic [15:0]                  cfg_data,
  output logic                         cfg_full,
  output logic [$clog2(CFG_DEPTH):0]   cfg_level,
  output logic                         cfg_drop,
  output logic                         spi_cmd_valid,
  input  logic                         spi_cmd_ready,
  output logic [15:0]                  spi_cmd_data,
  output logic [5:0]                   spi_cmd_slot,
  output logic                         frame_start,
  output logic                         batch_done,
  output logic [15:0]                  frame_cnt,
  output logic                         busy
);
  localparam int LW  = $clog2(CFG_DEPTH);
  localparam int LVW = LW + 1;
  localparam logic [5:0] LAST_SLOT = 6'(NUM_CH + NUM_AUX - 1);

`ifdef RHD_SEQ_CAL_EN
  typedef enum logic [1:0] {S_IDLE, S_FRAME, S_CAL} state_t;
  logic [3:0] cal_cnt_q, cal_cnt_d;
`else
  typedef enum logic [1:0] {S_IDLE, S_FRAME} state_t;
`endif

  state_t          state_q, state_d;
  logic            valid_q, valid_d;
  logic [5:0]      slot_q, slot_d;
  logic [15:0]     data_q, data_d;
  logic            used_q, used_d;
  logic            frame_start_q, frame_start_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;
  logic [15:0]     len_q, len_d;
  logic            cfg_drop_q, cfg_drop_d;
  logic [LW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, rd_ptr_inc;
  logic [LVW-1:0]  level_q, level_d;
  logic [15:0]     mem [CFG_DEPTH];

  logic            hs, pop, push_ok, head_avail, batch_hit, load;
  logic [15:0]     head_data, len_latch;
  logic [16:0]     cnt_inc;
  logic [5:0]      next_slot;

  assign hs         = valid_q & spi_cmd_ready;
  assign pop        = hs & used_q;
  assign push_ok    = cfg_wr & ((level_q != LVW'(CFG_DEPTH)) | pop);
  assign rd_ptr_inc = rd_ptr_q + 1'b1;
  // The head seen by a newly presented aux slot accounts for this cycle's pop but not its push.
  assign head_avail = pop ? (level_q >= LVW'(2)) : (level_q >= LVW'(1));
  assign head_data  = pop ? mem[rd_ptr_inc] : mem[rd_ptr_q];
  assign len_latch  = (packet_len == 16'd0) ? 16'd1 : packet_len;
  assign cnt_inc    = {1'b0, frame_cnt_q} + 17'd1;
  assign batch_hit  = hs && (state_q == S_FRAME) && (slot_q == LAST_SLOT) &&
                      (cnt_inc == {1'b0, len_q});

  always_comb begin
    state_d       = state_q;
    valid_d       = valid_q;
    slot_d        = slot_q;
    data_d        = data_q;
    used_d        = used_q;
    frame_start_d = 1'b0;
    frame_cnt_d   = frame_cnt_q;
    len_d         = len_q;
    load          = 1'b0;
    next_slot     = '0;
`ifdef RHD_SEQ_CAL_EN
    cal_cnt_d     = cal_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          len_d = len_latch;
`ifdef RHD_SEQ_CAL_EN
          state_d   = S_CAL;
          valid_d   = 1'b1;
          slot_d    = 6'd63;
          data_d    = 16'h5500;
          used_d    = 1'b0;
          cal_cnt_d = 4'd0;
`else
          state_d = S_FRAME;
          load    = 1'b1;
`endif
        end
      end
`ifdef RHD_SEQ_CAL_EN
      S_CAL: begin
        if (hs) begin
          if (cal_cnt_q == 4'd9) begin
            if (enable) begin
              state_d = S_FRAME;
              load    = 1'b1;
            end else begin
              state_d = S_IDLE;
              valid_d = 1'b0;
            end
          end else begin
            cal_cnt_d = cal_cnt_q + 4'd1;
            data_d    = DUMMY_CMD;
          end
        end
      end
`endif
      S_FRAME: begin
        if (hs) begin
          if (slot_q == LAST_SLOT) begin
            frame_cnt_d = cnt_inc[15:0];
            if (batch_hit) begin
              frame_cnt_d = 16'd0;
              len_d       = len_latch;
            end
            if (enable) begin
              load = 1'b1;
            end else begin
              state_d     = S_IDLE;
              valid_d     = 1'b0;
              used_d      = 1'b0;
              frame_cnt_d = 16'd0;
            end
          end else begin
            load      = 1'b1;
            next_slot = slot_q + 6'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      valid_d       = 1'b1;
      slot_d        = next_slot;
      frame_start_d = (next_slot == 6'd0);
      if (int'(next_slot) < NUM_CH) begin
        data_d = {2'b00, next_slot, 8'h00};
        used_d = 1'b0;
      end else if (head_avail) begin
        data_d = head_data;
        used_d = 1'b1;
      end else begin
        data_d = DUMMY_CMD;
        used_d = 1'b0;
      end
    end
  end

  assign rd_ptr_d   = pop ? rd_ptr_inc : rd_ptr_q;
  assign wr_ptr_d   = push_ok ? (wr_ptr_q + 1'b1) : wr_ptr_q;
  assign level_d    = level_q + LVW'(push_ok) - LVW'(pop);
  assign cfg_drop_d = cfg_wr & ~push_ok;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q       <= S_IDLE;
      valid_q       <= 1'b0;
      slot_q        <= '0;
      data_q        <= '0;
      used_q        <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
      len_q         <= 16'd1;
      cfg_drop_q    <= 1'b0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      level_q       <= '0;
`ifdef RHD_SEQ_CAL_EN
      cal_cnt_q     <= '0;
`endif
    end else begin
      state_q       <= state_d;
      valid_q       <= valid_d;
      slot_q        <= slot_d;
      data_q        <= data_d;
      used_q        <= used_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
      len_q         <= len_d;
      cfg_drop_q    <= cfg_drop_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      level_q       <= level_d;
`ifdef RHD_SEQ_CAL_EN
      cal_cnt_q     <= cal_cnt_d;
`endif
    end
  end

  // Storage has no reset; the pointers alone define what is valid.
  always_ff @(posedge aclk) begin
    if (push_ok) mem[wr_ptr_q] <= cfg_data;
  end

  assign cfg_full      = (level_q == LVW'(CFG_DEPTH));
  assign cfg_level     = level_q;
  assign cfg_drop      = cfg_drop_q;
  assign spi_cmd_valid = valid_q;
  assign spi_cmd_data  = data_q;
  assign spi_cmd_slot  = slot_q;
  assign frame_start   = frame_start_q;
  assign batch_done    = batch_hit & aresetn;
  assign frame_cnt     = frame_cnt_q;
  assign busy          = (state_q != S_IDLE);
endmodule

// File: tb/tb_rhd_cmd_sequencer.sv
// Scoreboard bench for rhd_cmd_sequencer: a frame-level reference model predicts every cycle and handshake.
module tb_rhd_cmd_sequencer;
  localparam logic [15:0] DUMMY = 16'hE800;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] packet_len = 16'd8;
  logic        cfg_wr = 1'b0;
  logic [15:0] cfg_data = 16'd0;
  logic        cfg_full, cfg_drop, spi_cmd_valid, frame_start, batch_done, busy;
  logic        spi_cmd_ready = 1'b0;
  logic [3:0]  cfg_level;
  logic [15:0] spi_cmd_data, frame_cnt;
  logic [5:0]  spi_cmd_slot;

  rhd_cmd_sequencer dut (
    .aclk(aclk), .aresetn(aresetn), .enable(enable), .packet_len(packet_len),
    .cfg_wr(cfg_wr), .cfg_data(cfg_data), .cfg_full(cfg_full), .cfg_level(cfg_level),
    .cfg_drop(cfg_drop), .spi_cmd_valid(spi_cmd_valid), .spi_cmd_ready(spi_cmd_ready),
    .spi_cmd_data(spi_cmd_data), .spi_cmd_slot(spi_cmd_slot), .frame_start(frame_start),
    .batch_done(batch_done), .frame_cnt(frame_cnt), .busy(busy)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic        valid;
    logic [5:0]  slot;
    logic [15:0] data;
    logic        busy;
    logic [3:0]  level;
    logic        full;
    logic        drop;
    logic        fstart;
    logic [15:0] fcnt;
    logic        bd;
  } cyc_t;

  typedef struct packed {
    logic [5:0]  slot;
    logic [15:0] data;
    logic        bd;
  } hs_t;

  cyc_t cyc_q[$];
  hs_t  hs_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   started = 1'b0;

  // Reference model: mode 0 idle, 1 frame, 2 calibration preamble.
  int          m_mode, m_slot, m_fcnt, m_len, m_cal;
  bit          m_valid, m_used, m_fstart, m_drop;
  logic [15:0] m_word;
  logic [15:0] m_fifo[$];

  function automatic void model_reset();
    m_mode = 0; m_slot = 0; m_fcnt = 0; m_len = 1; m_cal = 0;
    m_valid = 0; m_used = 0; m_fstart = 0; m_drop = 0; m_word = 16'd0;
    m_fifo.delete();
  endfunction

  task automatic step(input bit en, input bit rdy, input bit wr, input logic [15:0] wd,
                      input bit rstn, input logic [15:0] plen);
    bit hs, hit, pop, acc;
    int present;
    cyc_t c;
    hs_t h;
    logic [15:0] nf[$];
    enable = en; spi_cmd_ready = rdy; cfg_wr = wr; cfg_data = wd; aresetn = rstn; packet_len = plen;

    hs  = m_valid && rdy;
    hit = hs && m_mode == 1 && m_slot == 34 && (m_fcnt + 1 == m_len);
    c.valid = m_valid;
    c.slot  = m_valid ? 6'(m_slot) : 6'd0;
    c.data  = m_valid ? m_word : 16'd0;
    c.busy  = (m_mode != 0);
    c.level = 4'(m_fifo.size());
    c.full  = (m_fifo.size() == 8);
    c.drop  = m_drop;
    c.fstart = m_fstart;
    c.fcnt  = 16'(m_fcnt);
    c.bd    = hit && rstn;
    cyc_q.push_back(c);
    if (hs) begin
      h.slot = 6'(m_slot); h.data = m_word; h.bd = hit && rstn;
      hs_q.push_back(h);
    end

    if (!rstn) begin
      model_reset();
    end else begin
      nf = m_fifo;
      pop = hs && m_used;
      if (pop) void'(nf.pop_front());
      acc = wr && (m_fifo.size() < 8 || pop);
      m_drop = wr && !acc;
      m_fstart = 0;
      present = -1;
      if (m_mode == 0) begin
        if (en) begin
          m_len = (plen == 0) ? 1 : int'(plen);
`ifdef RHD_SEQ_CAL_EN
          m_mode = 2; m_cal = 0; m_valid = 1; m_slot = 63; m_word = 16'h5500; m_used = 0;
`else
          m_mode = 1; present = 0;
`endif
        end
      end else if (m_mode == 2) begin
        if (hs) begin
          if (m_cal == 9) begin
            if (en) begin m_mode = 1; present = 0; end
            else begin m_mode = 0; m_valid = 0; end
          end else begin
            m_cal++; m_word = DUMMY;
          end
        end
      end else if (hs) begin
        if (m_slot == 34) begin
          m_fcnt++;
          if (hit) begin m_fcnt = 0; m_len = (plen == 0) ? 1 : int'(plen); end
          if (en) present = 0;
          else begin m_mode = 0; m_valid = 0; m_used = 0; m_fcnt = 0; end
        end else begin
          present = m_slot + 1;
        end
      end
      if (present >= 0) begin
        m_valid = 1; m_slot = present; m_fstart = (present == 0);
        if (present < 32) begin m_word = 16'(present * 256); m_used = 0; end
        else if (nf.size() > 0) begin m_word = nf[0]; m_used = 1; end
        else begin m_word = DUMMY; m_used = 0; end
      end
      if (acc) nf.push_back(wd);
      m_fifo = nf;
    end
    @(posedge aclk); #1;
  endtask

  // Monitor: one per-cycle status comparison, plus one comparison per observed handshake.
  always @(negedge aclk) begin
    if (started) begin
      cyc_t a, e;
      hs_t  h;
      if (cyc_q.size() > 0) begin
        e = cyc_q.pop_front();
        a.valid = spi_cmd_valid;
        a.slot  = spi_cmd_valid ? spi_cmd_slot : 6'd0;
        a.data  = spi_cmd_valid ? spi_cmd_data : 16'd0;
        a.busy  = busy; a.level = cfg_level; a.full = cfg_full; a.drop = cfg_drop;
        a.fstart = frame_start; a.fcnt = frame_cnt; a.bd = batch_done;
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL cycle t=%0t got v=%b s=%0d d=%h busy=%b lvl=%0d full=%b drop=%b fs=%b fc=%0d bd=%b want v=%b s=%0d d=%h busy=%b lvl=%0d full=%b drop=%b fs=%b fc=%0d bd=%b",
                   $time, a.valid, a.slot, a.data, a.busy, a.level, a.full, a.drop, a.fstart, a.fcnt, a.bd,
                   e.valid, e.slot, e.data, e.busy, e.level, e.full, e.drop, e.fstart, e.fcnt, e.bd);
        end
      end
      if (spi_cmd_valid === 1'b1 && spi_cmd_ready === 1'b1) begin
        n_cmp++;
        if (hs_q.size() == 0) begin
          n_bad++;
          $display("FAIL handshake t=%0t got slot=%0d data=%h want none", $time, spi_cmd_slot, spi_cmd_data);
        end else begin
          h = hs_q.pop_front();
          if (spi_cmd_slot !== h.slot || spi_cmd_data !== h.data || batch_done !== h.bd) begin
            n_bad++;
            $display("FAIL handshake t=%0t got slot=%0d data=%h bd=%b want slot=%0d data=%h bd=%b",
                     $time, spi_cmd_slot, spi_cmd_data, batch_done, h.slot, h.data, h.bd);
          end else begin
            $display("hs slot=%0d data=%h bd=%b fcnt=%0d", spi_cmd_slot, spi_cmd_data, batch_done, frame_cnt);
          end
        end
      end
    end
  end

  task automatic wait_idle(input bit rdy_rand);
    for (int i = 0; i < 400 && m_mode != 0; i++)
      step(1'b0, rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0, 16'd0, 1'b1, 16'd8);
  endtask

  initial begin
    @(posedge aclk); #1;
    model_reset();
    started = 1'b1;
    step(0, 0, 0, 16'd0, 0, 16'd8);
    step(0, 0, 0, 16'd0, 1, 16'd8);

    // Full batch of 8 frames, ready held high, no config traffic.
    for (int i = 0; i < 8 * 35 + 5; i++) step(1, 1, 0, 16'd0, 1, 16'd8);
    wait_idle(0);
    step(0, 1, 0, 16'd0, 1, 16'd8);

    // Two config words queued in idle, consumed by the first aux slots.
    step(0, 0, 1, 16'h8010, 1, 16'd8);
    step(0, 0, 1, 16'h8120, 1, 16'd8);
    for (int i = 0; i < 36; i++) step(1, 1, 0, 16'd0, 1, 16'd8);
    wait_idle(0);

    // Overfill in idle, then run a frame with pushes every cycle so full+pop coincide.
    for (int i = 0; i < 9; i++) step(0, 0, 1, 16'(16'h8200 + i), 1, 16'd8);
    step(0, 0, 0, 16'd0, 1, 16'd8);
    for (int i = 0; i < 40; i++) step(1, 1, 1, 16'(16'h8300 + i), 1, 16'd8);
    wait_idle(0);

    // Drain the FIFO with ready toggling and sparse pushes.
    for (int i = 0; i < 700; i++)
      step(1, 1'(i % 2), ($urandom_range(0, 15) == 0), 16'($urandom), 1, 16'd8);
    wait_idle(1);

    // Enable dropped at slot 10 of frame 3 of an 8-frame batch.
    for (int i = 0; i < 400 && !(m_mode == 1 && m_fcnt == 3 && m_slot == 10); i++)
      step(1, 1, 0, 16'd0, 1, 16'd8);
    wait_idle(0);

    // packet_len of zero behaves as one: batch_done every frame.
    for (int i = 0; i < 3 * 35 + 2; i++) step(1, 1, 0, 16'd0, 1, 16'd0);
    wait_idle(0);

    // Randomized traffic on all inputs.
    for (int i = 0; i < 1500; i++)
      step(($urandom_range(0, 31) != 0), 1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
           16'($urandom), 1, 16'($urandom_range(0, 3)));

    // Reset mid-frame at slot 20.
    for (int i = 0; i < 200 && !(m_mode == 1 && m_slot == 20); i++)
      step(1, 1, ($urandom_range(0, 3) == 0), 16'($urandom), 1, 16'd8);
    step(1, 0, 0, 16'd0, 0, 16'd8);
    step(0, 0, 0, 16'd0, 1, 16'd8);
    step(0, 0, 0, 16'd0, 1, 16'd8);

    @(negedge aclk); #1;
    n_cmp++;
    if (hs_q.size() != 0) begin
      n_bad++;
      $display("FAIL hs_drain got %0d unmatched expected handshakes want 0", hs_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
